mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one unified memory port between the lc3b core's instruction-fetch port (port A, read-only) and data port (port B, read/write). It sits between the core's split memory interfaces and the single downstream memory/L2 port. Port B has priority, and a starvation counter guarantees forward progress for fetches. One transaction is outstanding at a time.

## Interface
- STARVE_LIMIT, 4: consecutive port-B grants allowed while port A waits before port A is forced to win; ≥1.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- read_a  in  1  fetch request, held until resp_a
- address_a  in  16  fetch address
- resp_a  out  1  fetch done, 1-cycle pulse
- rdata_a  out  16  fetch data, valid with resp_a
- read_b / write_b  in  1 each  data request, held until resp_b
- wmask_b  in  2  byte mask for write_b
- address_b  in  16  data address
- wdata_b  in  16  write data
- resp_b  out  1  data done, 1-cycle pulse
- rdata_b  out  16  read data, valid with resp_b
- mem_read / mem_write  out  1 each  downstream request, held until mem_resp
- mem_wmask  out  2  downstream byte mask
- mem_address  out  16  downstream address
- mem_wdata  out  16  downstream write data
- mem_resp  in  1  downstream done, 1-cycle pulse
- mem_rdata  in  16  downstream read data, valid with mem_resp

## Operation
- States: ARB_IDLE, ARB_I, ARB_D.
- ARB_IDLE:
  - If a B request (read_b|write_b) is pending and not starving A → ARB_D.
  - Else if read_a is pending → ARB_I.
  - Else stay.
- Starving: read_a=1 and d_streak==STARVE_LIMIT.
- On the grant edge, latch address/wdata/wmask/op of the winner into output registers.
- ARB_I: mem_read=1, mem_write=0, mem_wmask=2'b00.
- ARB_D: mem_write=write_b, mem_read=read_b & ~write_b. If both are asserted, the write wins and the read is dropped.
- In ARB_I or ARB_D, on mem_resp=1:
  - Forward the pulse combinationally to the granted port's resp only.
  - rdata_a / rdata_b = mem_rdata.
  - Next state is ARB_IDLE.
- The non-granted port's resp stays 0.
- mem_resp in ARB_IDLE is ignored: not forwarded, no state change.
- d_streak:
  - Width $clog2(STARVE_LIMIT+1).
  - +1 on each B grant made while read_a=1; saturate at STARVE_LIMIT.
  - Cleared on every A grant and on any IDLE cycle with read_a=0.
- A requester still asserting its request in the cycle after its resp is treated as a new request.
- Request inputs are sampled only in ARB_IDLE. Changes during a grant are ignored because the outputs are registered.

## Timing
- Reset (rst=1 at edge):
  - state=ARB_IDLE, d_streak=0.
  - mem_read=mem_write=0, mem_wmask=0, mem_address=0, mem_wdata=0.
  - resp_a=resp_b=0.
- Reset mid-transaction drops the downstream request on the next cycle. Any late mem_resp is ignored.
- Arbitration latency: request high in an IDLE cycle → downstream request asserted the next cycle.
- Response latency: 0 cycles, combinational resp path.
- Minimum transaction length: 2 cycles (grant cycle + mem_resp in the first granted cycle).
- Back-to-back: after resp, one IDLE cycle precedes the next grant.
- Downstream outputs are stable for the entire grant.

## Structure
- lc3b_types additions: enum lc3b_arb_state_t {ARB_IDLE, ARB_I, ARB_D}.
- Reuse lc3b_word for the 16-bit address/data buses.
- Single module. No sub-module needed; the starvation counter is inline.

## Test plan
- Fetch only: read_a=1, address_a=16'h3000, mem_rdata=16'h1234 with mem_resp 3 cycles after grant → mem_read=1 with mem_address=16'h3000 one cycle after request; resp_a pulse with rdata_a=16'h1234; resp_b=0 throughout.
- Simultaneous request: read_a=1, write_b=1, address_b=16'h4002, wdata_b=16'hBEEF, wmask_b=2'b01 → B is served first (mem_write=1, mem_wmask=2'b01, mem_wdata=16'hBEEF); A is granted after resp_b plus one IDLE cycle.
- Starvation (STARVE_LIMIT=4): read_a held high while read_b is re-asserted continuously → exactly 4 B grants, then an A grant; d_streak=0 afterwards.
- read_b=1 and write_b=1 together → mem_write=1, mem_read=0.
- mem_resp pulsed while IDLE → resp_a=resp_b=0, state stays ARB_IDLE.
- rst=1 asserted during ARB_D → next cycle all outputs are 0; a mem_resp 2 cycles later produces no resp_b.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the lc3b unified-memory arbiter.
package mem_arbiter_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_I,
    ARB_D
  } lc3b_arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the lc3b fetch port (A) and data port (B) onto one memory port.
// B has priority; a streak counter forces an A grant after STARVE_LIMIT B wins.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_a,
  input  logic [15:0] address_a,
  output logic        resp_a,
  output logic [15:0] rdata_a,
  input  logic        read_b,
  input  logic        write_b,
  input  logic [1:0]  wmask_b,
  input  logic [15:0] address_b,
  input  logic [15:0] wdata_b,
  output logic        resp_b,
  output logic [15:0] rdata_b,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_wmask,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata
);

  localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  lc3b_arb_state_t     r_state;
  logic [STREAK_W-1:0] r_d_streak;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [1:0]          r_mem_wmask;
  lc3b_word            r_mem_address;
  lc3b_word            r_mem_wdata;

  logic w_b_req;
  logic w_starving;

  assign w_b_req    = read_b | write_b;
  assign w_starving = read_a & (r_d_streak == STREAK_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ARB_IDLE;
      r_d_streak    <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_wmask   <= '0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (!read_a) begin
            r_d_streak <= '0;
          end
          if (w_b_req && !w_starving) begin
            r_state       <= ARB_D;
            r_mem_write   <= write_b;
            r_mem_read    <= read_b & ~write_b;
            r_mem_wmask   <= wmask_b;
            r_mem_address <= address_b;
            r_mem_wdata   <= wdata_b;
            // streak only counts B wins that made a waiting fetch wait longer
            if (read_a && (r_d_streak != STREAK_MAX)) begin
              r_d_streak <= r_d_streak + STREAK_W'(1);
            end
          end else if (read_a) begin
            r_state       <= ARB_I;
            r_mem_read    <= 1'b1;
            r_mem_write   <= 1'b0;
            r_mem_wmask   <= '0;
            r_mem_address <= address_a;
            r_mem_wdata   <= '0;
            r_d_streak    <= '0;
          end
        end
        ARB_I, ARB_D: begin
          if (mem_resp) begin
            r_state     <= ARB_IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_wmask <= '0;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_wmask   = r_mem_wmask;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;

  assign resp_a  = mem_resp & (r_state == ARB_I);
  assign resp_b  = mem_resp & (r_state == ARB_D);
  assign rdata_a = mem_rdata;
  assign rdata_b = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level arbitration and byte-memory model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        read_a;
  logic [15:0] address_a;
  logic        resp_a;
  logic [15:0] rdata_a;
  logic        read_b;
  logic        write_b;
  logic [1:0]  wmask_b;
  logic [15:0] address_b;
  logic [15:0] wdata_b;
  logic        resp_b;
  logic [15:0] rdata_b;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  int n_vec;
  int n_err;

  logic [7:0] m_lo [int];
  logic [7:0] m_hi [int];

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
    .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
    .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic lc3b_word mem_word(input lc3b_word a);
    int k;
    lc3b_word d;
    k = int'(a >> 1);
    d = a ^ 16'hA5C3;
    if (m_lo.exists(k)) d[7:0] = m_lo[k];
    if (m_hi.exists(k)) d[15:8] = m_hi[k];
    return d;
  endfunction

  task automatic idle_inputs();
    read_a = 1'b0; address_a = '0;
    read_b = 1'b0; write_b = 1'b0; wmask_b = '0; address_b = '0; wdata_b = '0;
    mem_resp = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    mem_resp = 1'b1;
    #1;
    n_vec++;
    if ({mem_read, mem_write, mem_wmask} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_read, mem_write, mem_wmask});
    end
    n_vec++;
    if ({mem_address, mem_wdata} !== 32'h0) begin
      n_err++; $display("FAIL reset_bus: got %h expected 00000000", {mem_address, mem_wdata});
    end
    n_vec++;
    if ({resp_a, resp_b} !== 2'b00) begin
      n_err++; $display("FAIL reset_resp: got %b expected 00", {resp_a, resp_b});
    end
    @(negedge clk);
    rst = 1'b0; mem_resp = 1'b0;
  endtask

  task automatic test_fetch_only();
    @(negedge clk);
    read_a = 1'b1; address_a = 16'h3000;
    #1;
    n_vec++;
    if (mem_read !== 1'b0) begin
      n_err++; $display("FAIL fetch_pregrant: got %b expected 0", mem_read);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_vec++;
      if ({mem_read, mem_write, mem_wmask, mem_address} !== {4'b1000, 16'h3000}) begin
        n_err++; $display("FAIL fetch_grant%0d: got %h expected 83000", i,
                          {mem_read, mem_write, mem_wmask, mem_address});
      end
      n_vec++;
      if ({resp_a, resp_b} !== 2'b00) begin
        n_err++; $display("FAIL fetch_wait_resp%0d: got %b expected 00", i, {resp_a, resp_b});
      end
    end
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = 16'h1234;
    #1;
    n_vec++;
    if ({resp_a, resp_b, rdata_a} !== {2'b10, 16'h1234}) begin
      n_err++; $display("FAIL fetch_resp: got %b/%h expected 10/1234", {resp_a, resp_b}, rdata_a);
    end
    @(negedge clk);
    mem_resp = 1'b0; read_a = 1'b0;
    #1;
    n_vec++;
    if ({mem_read, mem_write, resp_a, resp_b} !== 4'b0000) begin
      n_err++; $display("FAIL fetch_release: got %b expected 0000",
                        {mem_read, mem_write, resp_a, resp_b});
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    read_a = 1'b1; address_a = 16'h3002;
    write_b = 1'b1; address_b = 16'h4002; wdata_b = 16'hBEEF; wmask_b = 2'b01;
    #1;
    @(negedge clk); #1;
    n_vec++;
    if ({mem_read, mem_write, mem_wmask, mem_address, mem_wdata} !== {4'b0101, 16'h4002, 16'hBEEF}) begin
      n_err++; $display("FAIL prio_b_grant: got %h expected 54002beef",
                        {mem_read, mem_write, mem_wmask, mem_address, mem_wdata});
    end
    mem_resp = 1'b1; mem_rdata = 16'h0F0F;
    #1;
    n_vec++;
    if ({resp_a, resp_b} !== 2'b01) begin
      n_err++; $display("FAIL prio_b_resp: got %b expected 01", {resp_a, resp_b});
    end
    @(negedge clk);
    mem_resp = 1'b0; write_b = 1'b0;
    #1;
    n_vec++;
    if ({mem_read, mem_write} !== 2'b00) begin
      n_err++; $display("FAIL prio_gap: got %b expected 00", {mem_read, mem_write});
    end
    @(negedge clk); #1;
    n_vec++;
    if ({mem_read, mem_write, mem_wmask, mem_address} !== {4'b1000, 16'h3002}) begin
      n_err++; $display("FAIL prio_a_grant: got %h expected 83002",
                        {mem_read, mem_write, mem_wmask, mem_address});
    end
    mem_resp = 1'b1; mem_rdata = 16'h5678;
    #1;
    n_vec++;
    if ({resp_a, resp_b, rdata_a} !== {2'b10, 16'h5678}) begin
      n_err++; $display("FAIL prio_a_resp: got %b/%h expected 10/5678", {resp_a, resp_b}, rdata_a);
    end
    @(negedge clk);
    mem_resp = 1'b0; read_a = 1'b0;
  endtask

  // Both requesters held continuously: four B wins, then A, twice over.
  task automatic test_starvation();
    logic        exp_a;
    logic [15:0] exp_addr;
    @(negedge clk);
    read_a = 1'b1; address_a = 16'h3100;
    read_b = 1'b1; address_b = 16'h5000;
    #1;
    for (int i = 0; i < 10; i++) begin
      exp_a    = ((i % 5) == 4);
      exp_addr = exp_a ? 16'h3100 : 16'h5000;
      @(negedge clk); #1;
      n_vec++;
      if ({mem_read, mem_write, mem_address} !== {2'b10, exp_addr}) begin
        n_err++; $display("FAIL starve_grant%0d: got %b/%h expected 10/%h", i,
                          {mem_read, mem_write}, mem_address, exp_addr);
      end
      mem_resp = 1'b1; mem_rdata = 16'(i);
      #1;
      n_vec++;
      if ({resp_a, resp_b} !== {exp_a, ~exp_a}) begin
        n_err++; $display("FAIL starve_resp%0d: got %b expected %b", i,
                          {resp_a, resp_b}, {exp_a, ~exp_a});
      end
      @(negedge clk);
      mem_resp = 1'b0;
      if (i == 9) begin
        read_a = 1'b0; read_b = 1'b0;
      end
      #1;
      n_vec++;
      if ({mem_read, mem_write} !== 2'b00) begin
        n_err++; $display("FAIL starve_gap%0d: got %b expected 00", i, {mem_read, mem_write});
      end
    end
  endtask

  task automatic test_rw_both();
    @(negedge clk);
    read_b = 1'b1; write_b = 1'b1; address_b = 16'h6000; wdata_b = 16'h1111; wmask_b = 2'b11;
    #1;
    @(negedge clk); #1;
    n_vec++;
    if ({mem_read, mem_write, mem_wmask, mem_address, mem_wdata} !== {4'b0111, 16'h6000, 16'h1111}) begin
      n_err++; $display("FAIL rw_both: got %h expected 760001111",
                        {mem_read, mem_write, mem_wmask, mem_address, mem_wdata});
    end
    mem_resp = 1'b1;
    #1;
    n_vec++;
    if ({resp_a, resp_b} !== 2'b01) begin
      n_err++; $display("FAIL rw_both_resp: got %b expected 01", {resp_a, resp_b});
    end
    @(negedge clk);
    mem_resp = 1'b0; read_b = 1'b0; write_b = 1'b0;
  endtask

  task automatic test_idle_resp();
    @(negedge clk);
    idle_inputs();
    mem_resp = 1'b1; mem_rdata = 16'hFFFF;
    #1;
    n_vec++;
    if ({resp_a, resp_b} !== 2'b00) begin
      n_err++; $display("FAIL idle_resp: got %b expected 00", {resp_a, resp_b});
    end
    @(negedge clk);
    mem_resp = 1'b0; read_a = 1'b1; address_a = 16'h3456;
    #1;
    n_vec++;
    if ({mem_read, mem_write} !== 2'b00) begin
      n_err++; $display("FAIL idle_resp_state: got %b expected 00", {mem_read, mem_write});
    end
    @(negedge clk); #1;
    n_vec++;
    if ({mem_read, mem_address} !== {1'b1, 16'h3456}) begin
      n_err++; $display("FAIL idle_resp_regrant: got %b/%h expected 1/3456", mem_read, mem_address);
    end
    mem_resp = 1'b1;
    #1;
    n_vec++;
    if ({resp_a, resp_b} !== 2'b10) begin
      n_err++; $display("FAIL idle_resp_a: got %b expected 10", {resp_a, resp_b});
    end
    @(negedge clk);
    mem_resp = 1'b0; read_a = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    write_b = 1'b1; address_b = 16'h7000; wdata_b = 16'hCAFE; wmask_b = 2'b10;
    #1;
    @(negedge clk); #1;
    n_vec++;
    if ({mem_write, mem_address} !== {1'b1, 16'h7000}) begin
      n_err++; $display("FAIL rstmid_grant: got %b/%h expected 1/7000", mem_write, mem_address);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; write_b = 1'b0;
    #1;
    n_vec++;
    if ({mem_read, mem_write, mem_wmask, mem_address, mem_wdata, resp_a, resp_b} !== 38'h0) begin
      n_err++; $display("FAIL rstmid_outputs: got %h expected 0",
                        {mem_read, mem_write, mem_wmask, mem_address, mem_wdata, resp_a, resp_b});
    end
    @(negedge clk);
    @(negedge clk);
    mem_resp = 1'b1;
    #1;
    n_vec++;
    if ({resp_a, resp_b} !== 2'b00) begin
      n_err++; $display("FAIL rstmid_late_resp: got %b expected 00", {resp_a, resp_b});
    end
    @(negedge clk);
    mem_resp = 1'b0;
  endtask

  // Randomized traffic: the bench plays both requesters and the memory, and
  // predicts each grant from the priority/starvation rules.
  task automatic test_random(input int unsigned ncyc);
    int          busy;     // 0 none, 1 fetch, 2 data
    int          streak;
    int          cnt;
    int          lat;
    int          op;
    logic        a_act, b_act, a_done, b_done;
    logic        e_rd, e_wr;
    logic [1:0]  e_mask;
    logic [15:0] e_addr, e_wdata, e_rdata;
    busy = 0; streak = 0; cnt = 0; lat = 0;
    a_act = 1'b0; b_act = 1'b0; a_done = 1'b0; b_done = 1'b0;
    e_rd = 1'b0; e_wr = 1'b0; e_mask = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    @(negedge clk);
    idle_inputs(); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (a_done) begin a_done = 1'b0; a_act = 1'b0; read_a = 1'b0; end
      if (b_done) begin b_done = 1'b0; b_act = 1'b0; read_b = 1'b0; write_b = 1'b0; end
      if (!a_act && $urandom_range(0, 2) == 0) begin
        a_act = 1'b1; read_a = 1'b1;
        address_a = 16'h8000 | (16'($urandom_range(0, 31)) << 1);
      end
      if (!b_act && $urandom_range(0, 1) == 0) begin
        b_act = 1'b1;
        op = int'($urandom_range(0, 2));
        read_b  = (op != 1);
        write_b = (op != 0);
        address_b = 16'h8000 | (16'($urandom_range(0, 31)) << 1);
        wdata_b = 16'($urandom);
        wmask_b = 2'($urandom_range(0, 3));
      end
      mem_rdata = 16'($urandom);
      mem_resp  = 1'b0;
      if (busy != 0 && cnt == lat) begin
        mem_resp = 1'b1;
        if (e_rd) mem_rdata = mem_word(e_addr);
      end else if (busy == 0 && $urandom_range(0, 7) == 0) begin
        mem_resp = 1'b1;
      end
      e_rdata = mem_rdata;
      #1;
      if (busy == 0) begin
        n_vec++;
        if ({mem_read, mem_write, resp_a, resp_b} !== 4'b0000) begin
          n_err++; $display("FAIL rnd_idle c=%0d: got %b expected 0000", c,
                            {mem_read, mem_write, resp_a, resp_b});
        end
        if ((read_b || write_b) && !(read_a && streak == int'(LIMIT))) begin
          busy = 2;
          e_rd = read_b & ~write_b; e_wr = write_b; e_mask = wmask_b;
          e_addr = address_b; e_wdata = wdata_b;
          streak = read_a ? ((streak + 1 > int'(LIMIT)) ? int'(LIMIT) : streak + 1) : 0;
        end else if (read_a) begin
          busy = 1;
          e_rd = 1'b1; e_wr = 1'b0; e_mask = 2'b00; e_addr = address_a;
          streak = 0;
        end else begin
          streak = 0;
        end
        cnt = 0;
        lat = int'($urandom_range(0, 3));
      end else begin
        n_vec++;
        if ({mem_read, mem_write, mem_wmask, mem_address} !== {e_rd, e_wr, e_mask, e_addr}) begin
          n_err++; $display("FAIL rnd_bus c=%0d: got %h expected %h", c,
                            {mem_read, mem_write, mem_wmask, mem_address}, {e_rd, e_wr, e_mask, e_addr});
        end
        if (busy == 2) begin
          n_vec++;
          if (mem_wdata !== e_wdata) begin
            n_err++; $display("FAIL rnd_wdata c=%0d: got %h expected %h", c, mem_wdata, e_wdata);
          end
        end
        if (mem_resp) begin
          n_vec++;
          if ({resp_a, resp_b} !== ((busy == 1) ? 2'b10 : 2'b01)) begin
            n_err++; $display("FAIL rnd_resp c=%0d: got %b expected %b", c,
                              {resp_a, resp_b}, (busy == 1) ? 2'b10 : 2'b01);
          end
          n_vec++;
          if (((busy == 1) ? rdata_a : rdata_b) !== e_rdata) begin
            n_err++; $display("FAIL rnd_rdata c=%0d: got %h expected %h", c,
                              (busy == 1) ? rdata_a : rdata_b, e_rdata);
          end
          if (e_wr) begin
            if (e_mask[0]) m_lo[int'(e_addr >> 1)] = e_wdata[7:0];
            if (e_mask[1]) m_hi[int'(e_addr >> 1)] = e_wdata[15:8];
          end
          if (busy == 1) a_done = 1'b1;
          else b_done = 1'b1;
          busy = 0;
        end else begin
          n_vec++;
          if ({resp_a, resp_b} !== 2'b00) begin
            n_err++; $display("FAIL rnd_noresp c=%0d: got %b expected 00", c, {resp_a, resp_b});
          end
          cnt++;
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_priority();
    test_starvation();
    test_rw_both();
    test_idle_resp();
    test_reset_mid();
    test_random(2000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
